// File: rtl/next_line_prefetcher.sv
// ============================================================================
// Module   : next_line_prefetcher
// Purpose  : Sequential next-line prefetcher for the 2-way L1 cache. A demand
//            miss trigger selects the line PF_DISTANCE lines ahead. That line
//            is fetched over the shared pmem port while the cache is not using
//            the port, and it is held in a one-entry line buffer. The buffer
//            is offered to the cache when the cache looks up that line.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            trigger_valid_i/address  - demand-miss pulse and miss address
//            query_address_i          - address the cache is looking up now
//            pf_consume_i             - cache copied the buffer into a way
//            prefetch_rdata_o/ready_o - buffered line and its hit indication
//            pf_cline_address_o       - line address of buffered/in-flight line
//            demand_busy_i            - cache owns pmem; no new fetch may start
//            pf_pmem_read_o/address_o - line read request to the arbiter
//            pf_pmem_rdata_i/resp_i   - returned line and response strobe
// Option   : PF_STATS_EN adds pf_issued_count_o / pf_used_count_o, which are
//            saturating 32-bit counters of issued and consumed prefetches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_line_prefetcher #(
   parameter int unsigned s_offset    = 5,
   parameter int unsigned s_line      = 256,
   parameter int unsigned PF_DISTANCE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trigger_valid_i,
   input  logic [31:0]       trigger_address_i,
   input  logic [31:0]       query_address_i,
   input  logic              pf_consume_i,
   output logic [s_line-1:0] prefetch_rdata_o,
   output logic              prefetch_ready_o,
   output logic [31:0]       pf_cline_address_o,
   input  logic              demand_busy_i,
   output logic              pf_pmem_read_o,
   output logic [31:0]       pf_pmem_address_o,
   input  logic [s_line-1:0] pf_pmem_rdata_i,
`ifdef PF_STATS_EN
   input  logic              pf_pmem_resp_i,
   output logic [31:0]       pf_issued_count_o,
   output logic [31:0]       pf_used_count_o
`else
   input  logic              pf_pmem_resp_i
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_BUS = 2'd1,
      FETCH    = 2'd2,
      FULL     = 2'd3
   } state_t;

   localparam logic [31:0] c_STEP = 32'(PF_DISTANCE) << s_offset;

   state_t            state_q, state_d;
   logic [31:0]       buf_addr_q, buf_addr_d;
   logic [s_line-1:0] buf_data_q, buf_data_d;
   logic [31:0]       pend_addr_q, pend_addr_d;
   logic              pend_valid_q, pend_valid_d;

   logic [31:0]       w_target;
   logic              w_new_target;
   logic              w_issue;
   logic              w_use;

   // Byte-offset bits play no part in line matching.
   logic              w_unused_offsets;
   assign w_unused_offsets = ^{query_address_i[s_offset-1:0],
                               trigger_address_i[s_offset-1:0]};

   // Line-align the miss address, then step ahead; wraps modulo 2^32.
   assign w_target     = {trigger_address_i[31:s_offset], {s_offset{1'b0}}} + c_STEP;
   assign w_new_target = trigger_valid_i && (w_target != buf_addr_q);

   always_comb begin
      state_d      = state_q;
      buf_addr_d   = buf_addr_q;
      buf_data_d   = buf_data_q;
      pend_addr_d  = pend_addr_q;
      pend_valid_d = pend_valid_q;
      w_issue      = 1'b0;
      w_use        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (trigger_valid_i) begin
               buf_addr_d = w_target;
               state_d    = WAIT_BUS;
            end
         end

         WAIT_BUS: begin
            if (w_new_target) begin
               buf_addr_d = w_target;
            end
            if (!demand_busy_i) begin
               state_d = FETCH;
               w_issue = 1'b1;
            end
         end

         FETCH: begin
            // The outstanding read cannot be cancelled, so a newer target is
            // parked until the response comes back.
            if (w_new_target) begin
               pend_addr_d  = w_target;
               pend_valid_d = 1'b1;
            end
            if (pf_pmem_resp_i) begin
               if (pend_valid_d) begin
                  buf_addr_d   = pend_addr_d;
                  pend_valid_d = 1'b0;
                  state_d      = WAIT_BUS;
               end else begin
                  buf_data_d = pf_pmem_rdata_i;
                  state_d    = FULL;
               end
            end
         end

         FULL: begin
            w_use = pf_consume_i;
            // A trigger together with a consume always restarts a fetch,
            // even if the target equals the line just consumed.
            if (w_new_target || (trigger_valid_i && pf_consume_i)) begin
               buf_addr_d = w_target;
               state_d    = WAIT_BUS;
            end else if (pf_consume_i) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         buf_addr_q   <= '0;
         buf_data_q   <= '0;
         pend_addr_q  <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_addr_q   <= buf_addr_d;
         buf_data_q   <= buf_data_d;
         pend_addr_q  <= pend_addr_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   assign pf_cline_address_o = buf_addr_q;
   assign prefetch_rdata_o   = buf_data_q;
   assign prefetch_ready_o   = (state_q == FULL) &&
                               (query_address_i[31:s_offset] == buf_addr_q[31:s_offset]);
   assign pf_pmem_read_o     = (state_q == FETCH);
   assign pf_pmem_address_o  = (state_q == FETCH) ? buf_addr_q : 32'd0;

`ifdef PF_STATS_EN
   logic [31:0] issued_cnt_q, issued_cnt_d;
   logic [31:0] used_cnt_q,   used_cnt_d;

   always_comb begin
      issued_cnt_d = issued_cnt_q;
      used_cnt_d   = used_cnt_q;
      if (w_issue && (issued_cnt_q != 32'hFFFF_FFFF)) begin
         issued_cnt_d = issued_cnt_q + 32'd1;
      end
      if (w_use && (used_cnt_q != 32'hFFFF_FFFF)) begin
         used_cnt_d = used_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issued_cnt_q <= '0;
         used_cnt_q   <= '0;
      end else begin
         issued_cnt_q <= issued_cnt_d;
         used_cnt_q   <= used_cnt_d;
      end
   end

   assign pf_issued_count_o = issued_cnt_q;
   assign pf_used_count_o   = used_cnt_q;
`else
   logic w_unused_stats;
   assign w_unused_stats = w_issue ^ w_use;
`endif

endmodule

`default_nettype wire

// File: tb/tb_next_line_prefetcher.sv
`default_nettype none

module tb_next_line_prefetcher;

   logic          clk;
   logic          rst;
   logic          trigger_valid;
   logic [31:0]   trigger_address;
   logic [31:0]   query_address;
   logic          pf_consume;
   logic [255:0]  prefetch_rdata;
   logic          prefetch_ready;
   logic [31:0]   pf_cline_address;
   logic          demand_busy;
   logic          pf_pmem_read;
   logic [31:0]   pf_pmem_address;
   logic [255:0]  pf_pmem_rdata;
   logic          pf_pmem_resp;
`ifdef PF_STATS_EN
   logic [31:0]   pf_issued_count;
   logic [31:0]   pf_used_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [255:0] c_D_A5 = {8{32'hA5A5_A5A5}};
   localparam logic [255:0] c_D_1  = {8{32'h1111_2222}};
   localparam logic [255:0] c_D_X  = {8{32'hDEAD_BEEF}};
   localparam logic [255:0] c_D_3  = {8{32'h3C3C_0F0F}};
   localparam logic [255:0] c_D_8  = {8{32'h8080_0808}};

   next_line_prefetcher dut (
      .clk                (clk),
      .rst                (rst),
      .trigger_valid_i    (trigger_valid),
      .trigger_address_i  (trigger_address),
      .query_address_i    (query_address),
      .pf_consume_i       (pf_consume),
      .prefetch_rdata_o   (prefetch_rdata),
      .prefetch_ready_o   (prefetch_ready),
      .pf_cline_address_o (pf_cline_address),
      .demand_busy_i      (demand_busy),
      .pf_pmem_read_o     (pf_pmem_read),
      .pf_pmem_address_o  (pf_pmem_address),
      .pf_pmem_rdata_i    (pf_pmem_rdata),
`ifdef PF_STATS_EN
      .pf_pmem_resp_i     (pf_pmem_resp),
      .pf_issued_count_o  (pf_issued_count),
      .pf_used_count_o    (pf_used_count)
`else
      .pf_pmem_resp_i     (pf_pmem_resp)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic trigger(input logic [31:0] a);
      trigger_valid   = 1'b1;
      trigger_address = a;
      step();
      trigger_valid   = 1'b0;
   endtask

   task automatic respond(input logic [255:0] d);
      pf_pmem_resp  = 1'b1;
      pf_pmem_rdata = d;
      step();
      pf_pmem_resp  = 1'b0;
      pf_pmem_rdata = '0;
   endtask

   initial begin
      rst             = 1'b1;
      trigger_valid   = 1'b0;
      trigger_address = '0;
      query_address   = '0;
      pf_consume      = 1'b0;
      demand_busy     = 1'b0;
      pf_pmem_rdata   = '0;
      pf_pmem_resp    = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst_read",  256'(pf_pmem_read), 256'd0);
      check("rst_addr",  256'(pf_pmem_address), 256'd0);
      check("rst_ready", 256'(prefetch_ready), 256'd0);
      check("rst_rdata", prefetch_rdata, 256'd0);
      check("rst_cline", 256'(pf_cline_address), 256'd0);
`ifdef PF_STATS_EN
      check("rst_issued", 256'(pf_issued_count), 256'd0);
      check("rst_used",   256'(pf_used_count), 256'd0);
`endif

      // Basic fetch: 0x1234 -> line 0x1240
      trigger(32'h0000_1234);
      check("basic_wait_read", 256'(pf_pmem_read), 256'd0);
      check("basic_wait_cline", 256'(pf_cline_address), 256'h1240);
      step();
      check("basic_read", 256'(pf_pmem_read), 256'd1);
      check("basic_addr", 256'(pf_pmem_address), 256'h1240);
      step();
      check("basic_hold_read", 256'(pf_pmem_read), 256'd1);
      check("basic_hold_addr", 256'(pf_pmem_address), 256'h1240);
      query_address = 32'h0000_1244;
      check("basic_ready_early", 256'(prefetch_ready), 256'd0);
      respond(c_D_A5);
      check("basic_ready", 256'(prefetch_ready), 256'd1);
      check("basic_rdata", prefetch_rdata, c_D_A5);
      check("basic_cline", 256'(pf_cline_address), 256'h1240);
      check("basic_read_drop", 256'(pf_pmem_read), 256'd0);
      query_address = 32'h0000_1260;
      #1;
      check("basic_other_line", 256'(prefetch_ready), 256'd0);
      pf_consume = 1'b1;
      step();
      pf_consume = 1'b0;
      query_address = 32'h0000_1244;
      #1;
      check("basic_consumed", 256'(prefetch_ready), 256'd0);

      // Bus gating: 0x100 -> 0x120 held off by demand_busy
      demand_busy = 1'b1;
      trigger(32'h0000_0100);
      for (int i = 0; i < 5; i++) begin
         step();
         check("gate_read_low", 256'(pf_pmem_read), 256'd0);
      end
      demand_busy = 1'b0;
      step();
      check("gate_read", 256'(pf_pmem_read), 256'd1);
      check("gate_addr", 256'(pf_pmem_address), 256'h120);
      respond(c_D_1);
      query_address = 32'h0000_0130;
      #1;
      check("gate_ready", 256'(prefetch_ready), 256'd1);
      check("gate_rdata", prefetch_rdata, c_D_1);

      // Consume plus trigger in FULL: 0x120 dropped, 0x820 fetched
      query_address = 32'h0000_0120;
      pf_consume    = 1'b1;
      trigger(32'h0000_0800);
      pf_consume    = 1'b0;
      check("ct_ready", 256'(prefetch_ready), 256'd0);
      check("ct_cline", 256'(pf_cline_address), 256'h820);
      step();
      check("ct_read", 256'(pf_pmem_read), 256'd1);
      check("ct_addr", 256'(pf_pmem_address), 256'h820);
      respond(c_D_8);
      query_address = 32'h0000_0820;
      #1;
      check("ct_ready_new", 256'(prefetch_ready), 256'd1);
      check("ct_rdata", prefetch_rdata, c_D_8);
      pf_consume = 1'b1;
      step();
      pf_consume = 1'b0;

      // Retarget during FETCH: 0x120 response discarded, 0x420 fetched
      trigger(32'h0000_0100);
      step();
      check("rt_addr1", 256'(pf_pmem_address), 256'h120);
      trigger(32'h0000_0400);
      check("rt_hold_read", 256'(pf_pmem_read), 256'd1);
      check("rt_hold_addr", 256'(pf_pmem_address), 256'h120);
      respond(c_D_X);
      query_address = 32'h0000_0120;
      #1;
      check("rt_no_ready_old", 256'(prefetch_ready), 256'd0);
      check("rt_read_drop", 256'(pf_pmem_read), 256'd0);
      check("rt_cline", 256'(pf_cline_address), 256'h420);
      step();
      check("rt_no_ready_old2", 256'(prefetch_ready), 256'd0);
      check("rt_read2", 256'(pf_pmem_read), 256'd1);
      check("rt_addr2", 256'(pf_pmem_address), 256'h420);
      respond(c_D_3);
      check("rt_no_ready_old3", 256'(prefetch_ready), 256'd0);
      query_address = 32'h0000_0420;
      #1;
      check("rt_ready", 256'(prefetch_ready), 256'd1);
      check("rt_rdata", prefetch_rdata, c_D_3);

      // Same-target trigger in FULL is ignored
      trigger(32'h0000_0400);
      check("full_same_ready", 256'(prefetch_ready), 256'd1);
      check("full_same_read", 256'(pf_pmem_read), 256'd0);
      pf_consume = 1'b1;
      step();
      pf_consume = 1'b0;

      // Wrap at the top of the address space, then reset mid-FETCH
      trigger(32'hFFFF_FFE7);
      check("wrap_cline", 256'(pf_cline_address), 256'd0);
      step();
      check("wrap_read", 256'(pf_pmem_read), 256'd1);
      check("wrap_addr", 256'(pf_pmem_address), 256'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstf_read", 256'(pf_pmem_read), 256'd0);
`ifdef PF_STATS_EN
      check("rstf_issued", 256'(pf_issued_count), 256'd0);
`endif
      query_address = 32'h0000_0000;
      respond(c_D_A5);
      check("rstf_late_ready", 256'(prefetch_ready), 256'd0);
      check("rstf_late_rdata", prefetch_rdata, 256'd0);
      trigger(32'h0000_2000);
      step();
      check("post_rst_addr", 256'(pf_pmem_address), 256'h2020);
`ifdef PF_STATS_EN
      check("post_rst_issued", 256'(pf_issued_count), 256'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
